// File: rtl/prog_clock_divider_if.sv
// Control and status bundle for prog_clock_divider: divisor/mode programming in,
// divided clock and run status out.
interface prog_clock_divider_if #(
   parameter int WIDTH   = 25,
   parameter int BURST_W = 16
);
   logic [WIDTH-1:0]   div_val;
   logic               div_load;
   logic               mode;
   logic [BURST_W-1:0] burst_len;
   logic               start;
   logic               stop;
   logic               clkout;
   logic               tick;
   logic               busy;
   logic               done;

   modport master (
      output div_val, div_load, mode, burst_len, start, stop,
      input  clkout, tick, busy, done
   );

   modport slave (
      input  div_val, div_load, mode, burst_len, start, stop,
      output clkout, tick, busy, done
   );
endinterface

// File: rtl/prog_clock_divider.sv
// Runtime-programmable 50%-duty clock divider with continuous and N-pulse burst modes.
//
// state | meaning
// IDLE  | clkout held low, counter held, waiting for start
// RUN   | continuous toggling until stop (ends after a full low half period boundary)
// BURST | toggling until burst_cnt falling edges have been produced
module prog_clock_divider #(
   parameter int WIDTH       = 25,
   parameter int DEFAULT_DIV = 10,
   parameter int BURST_W     = 16
) (
   input logic                 clkin,
   input logic                 rst,
   prog_clock_divider_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, BURST = 2'd2} state_t;

   localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   div_active_q, div_active_d;
   logic [WIDTH-1:0]   div_pending_q, div_pending_d;
   logic               load_flag_q, load_flag_d;
   logic               stop_pend_q, stop_pend_d;
   logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
   logic               clkout_q, clkout_d;
   logic               tick_q, tick_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [WIDTH-1:0]   div_next;
   logic [WIDTH-1:0]   div_reload;
   logic               take_div;
   logic               cnt_zero;

   always_comb begin
      // A div_load landing on a start or reload edge is used immediately.
      div_next      = bus.div_load ? bus.div_val : div_pending_q;
      take_div      = load_flag_q | bus.div_load;
      div_reload    = take_div ? div_next : div_active_q;
      cnt_zero      = (cnt_q == '0);

      state_d       = state_q;
      cnt_d         = cnt_q;
      div_active_d  = div_active_q;
      div_pending_d = div_next;
      load_flag_d   = take_div;
      stop_pend_d   = stop_pend_q;
      burst_cnt_d   = burst_cnt_q;
      clkout_d      = clkout_q;
      done_d        = 1'b0;

      case (state_q)
         IDLE: begin
            clkout_d = 1'b0;
            if (bus.start) begin
               div_active_d = div_reload;
               load_flag_d  = 1'b0;
               cnt_d        = div_reload;
               stop_pend_d  = 1'b0;
               if (!bus.mode) begin
                  state_d = RUN;
               end else if (bus.burst_len != '0) begin
                  state_d     = BURST;
                  burst_cnt_d = bus.burst_len;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (bus.stop && !clkout_q) begin
               state_d     = IDLE;
               cnt_d       = '0;
               stop_pend_d = 1'b0;
            end else begin
               if (bus.stop) stop_pend_d = 1'b1;
               if (cnt_zero) begin
                  clkout_d     = ~clkout_q;
                  div_active_d = div_reload;
                  load_flag_d  = 1'b0;
                  cnt_d        = div_reload;
                  if (clkout_q && (stop_pend_q || bus.stop)) begin
                     state_d     = IDLE;
                     cnt_d       = '0;
                     stop_pend_d = 1'b0;
                  end
               end else begin
                  cnt_d = cnt_q - WIDTH'(1);
               end
            end
         end
         BURST: begin
            if (cnt_zero) begin
               clkout_d     = ~clkout_q;
               div_active_d = div_reload;
               load_flag_d  = 1'b0;
               cnt_d        = div_reload;
               if (clkout_q) begin
                  burst_cnt_d = burst_cnt_q - BURST_W'(1);
                  if (burst_cnt_q == BURST_W'(1)) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                     done_d  = 1'b1;
                  end
               end
            end else begin
               cnt_d = cnt_q - WIDTH'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      tick_d = clkout_d & ~clkout_q;
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clkin) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         div_active_q  <= DIV_RST;
         div_pending_q <= DIV_RST;
         load_flag_q   <= 1'b0;
         stop_pend_q   <= 1'b0;
         burst_cnt_q   <= '0;
         clkout_q      <= 1'b0;
         tick_q        <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         div_active_q  <= div_active_d;
         div_pending_q <= div_pending_d;
         load_flag_q   <= load_flag_d;
         stop_pend_q   <= stop_pend_d;
         burst_cnt_q   <= burst_cnt_d;
         clkout_q      <= clkout_d;
         tick_q        <= tick_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign bus.clkout = clkout_q;
   assign bus.tick   = tick_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
endmodule

// File: doc/prog_clock_divider.md
Name: prog_clock_divider

Overview:
- Parametrised, runtime-programmable successor to the fixed slow-clock divider.
- Derives a slow 50%-duty clock from clkin for single-stepping and slow-running the down-sampling processor.
- Adds a loadable divisor, continuous and burst (N-pulse) modes, glitch-free stop, and a rising-edge tick strobe for logic that stays in the clkin domain.

Parameters:
- WIDTH, 25, width of divisor and half-period counter.
- DEFAULT_DIV, 10, divisor value after reset (half period = DEFAULT_DIV+1 clkin cycles).
- BURST_W, 16, width of the burst length field.

Ports:
- clkin  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- div_val  in  WIDTH  new divisor value.
- div_load  in  1  capture div_val into pending divisor.
- mode  in  1  0 = continuous, 1 = burst; sampled on start.
- burst_len  in  BURST_W  number of slow-clock rising edges in burst mode; sampled on start.
- start  in  1  single-cycle request to begin; honoured only in IDLE.
- stop  in  1  request to end continuous run.
- clkout  out  1  divided clock (registered).
- tick  out  1  one-cycle pulse coincident with each clkout 0->1.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle pulse when a burst completes.

Behaviour:
- Reset (rst=1 at posedge) forces the following, overriding all other inputs including mid-run:
  - state=IDLE, counter=0, clkout=0, tick=0, done=0, busy=0.
  - div_active=div_pending=DEFAULT_DIV, load_flag=0, stop_pend=0, burst_cnt=0.
- Half period: clkout toggles when counter==0 in RUN/BURST, and counter reloads with div_active. Otherwise counter decrements by 1, modulo 2^WIDTH never reached.
  - Half period = div_active+1 cycles; full period = 2*(div_active+1).
  - div_active=0 gives clkin/2.
- Divisor load: div_load=1 sets div_pending<=div_val and load_flag<=1.
  - div_pending is copied to div_active only at a reload point (counter==0 while running) or on start. No shortened or stretched half periods.
  - A later div_load before the reload point overwrites the earlier one.
  - div_load and start in the same cycle: start uses the new div_val.
- FSM states IDLE, RUN, BURST.
  - IDLE: clkout=0, counter held.
    - start & mode=0 -> RUN.
    - start & mode=1 & burst_len!=0 -> BURST, burst_cnt<=burst_len.
    - start & mode=1 & burst_len==0 -> stay IDLE, done=1 next cycle, no edges.
    - On any accepted start: counter<=div_active (updated from pending), clkout stays 0. The first rising edge occurs div_active+1 cycles after the start edge.
  - RUN: toggles indefinitely.
    - stop=1 sets stop_pend.
    - If clkout==0 when stop is seen: IDLE next edge, counter<=0.
    - If clkout==1: continue until the next 1->0 toggle, which also enters IDLE. clkout low-phase is never truncated below a full half period except by rst.
    - stop and start together in RUN: start ignored.
  - BURST: each 1->0 toggle decrements burst_cnt.
    - When the toggle takes burst_cnt 1->0: state<=IDLE, done pulses that same edge, clkout ends low.
    - stop ignored in BURST.
- start while busy: ignored, no effect on counter or phase.
- tick: registered high exactly on edges where clkout transitions 0->1; low otherwise.
- busy: =(state!=IDLE), registered.

Test Plan:
- Reset then start (mode=0, DEFAULT_DIV=10) -> busy=1 next cycle; first clkout rise 11 cycles after start edge; period 22 cycles; tick one cycle wide on each rise.
- div_load div_val=3 mid-high-phase in RUN -> current half period completes at 11 cycles; subsequent half periods 4 cycles; no clkout pulse shorter than 4 cycles.
- mode=1, burst_len=3, div=1 -> exactly 3 rises, 3 ticks, period 4 cycles; done pulses on the 3rd falling edge; busy drops the same cycle; clkout=0 afterwards.
- mode=1, burst_len=0 -> no clkout activity; done=1 one cycle after start; busy stays 0.
- RUN with div=5, stop during clkout=1 -> clkout completes its 6-cycle high phase, falls, busy=0. Stop during clkout=0 -> IDLE next cycle.
- rst asserted mid-BURST with clkout=1 -> next edge clkout=0, busy=0, tick=0, done=0; div_active back to 10; start afterwards behaves as the first scenario.
